id_stage_pipe: RTL and testbench

- Parametrised, pipelined RV32 decode stage. Successor to the single-cycle decode block.
- Holds the architectural register file (x0 hardwired to zero) and generates sign-extended immediates.
- Detects load-use hazards and registers the decoded instruction into an ID/EX pipeline register with a valid/ready handshake, stall and flush.
- Sits between the IF/ID register (upstream) and the EX stage (downstream); the WB stage drives the write port.

---
 rtl/id_stage_pipe_pkg.sv | 38 +++
 rtl/id_stage_pipe_reg_file.sv | 73 +++++++
 rtl/id_stage_pipe.sv | 159 +++++++++++++++
 tb/tb_id_stage_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate formats and the
// opcode-to-immediate-format mapping used by the ID stage.
package rv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
            OP_STORE:                            fmt = IMM_S;
            OP_BRANCH:                           fmt = IMM_B;
            OP_LUI, OP_AUIPC:                    fmt = IMM_U;
            OP_JAL:                              fmt = IMM_J;
            default:                             fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/id_stage_pipe_reg_file.sv
// Two-read / one-write architectural register file with x0 hardwired to zero.
// Optional same-cycle write-back forwarding when ID_WB_BYPASS_EN is defined.
module reg_file_p #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);
    import rv_pkg::*;

    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic [AW-1:0]   waddr_s;
    logic [AW-1:0]   raddr1_s;
    logic [AW-1:0]   raddr2_s;
    logic            wr_en_s;

    // Upper index bits are dropped so RV32E aliases x16..x31 onto x0..x15.
    assign waddr_s  = waddr_i[AW-1:0];
    assign raddr1_s = raddr1_i[AW-1:0];
    assign raddr2_s = raddr2_i[AW-1:0];
    assign wr_en_s  = we_i & (waddr_s != {AW{1'b0}});

    // Next-state of the register array.
    always_comb begin
        regs_d = regs_q;
        if (wr_en_s) begin
            regs_d[waddr_s] = wdata_i;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports, optionally forwarding the write-back value.
    always_comb begin
        rdata1_o = (raddr1_s == {AW{1'b0}}) ? '0 : regs_q[raddr1_s];
        rdata2_o = (raddr2_s == {AW{1'b0}}) ? '0 : regs_q[raddr2_s];
`ifdef ID_WB_BYPASS_EN
        if (wr_en_s && (waddr_s == raddr1_s)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = rdata1_o;
        end
        if (wr_en_s && (waddr_s == raddr2_s)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = rdata2_o;
        end
`endif
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined RV32 decode stage: register file read, immediate generation, load-use
// hazard stall and ID/EX register with valid/ready. Option: ID_WB_BYPASS_EN.
module id_stage_pipe
    import rv_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          NUM_REGS = 32,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_rs1_data_o,
    output logic [XLEN-1:0] out_rs2_data_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [4:0]      out_rd_o,
    output logic [6:0]      out_opcode_o,
    output logic [2:0]      out_funct3_o,
    output logic [6:0]      out_funct7_o
);

    logic [4:0]        rs1_s, rs2_s;
    logic [XLEN-1:0]   rs1_data_s, rs2_data_s;
    logic              haz_s, accept_s;
    logic signed [31:0] imm32_s;
    logic [XLEN-1:0]   imm_s;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [6:0]        opcode_q, opcode_d, funct7_q, funct7_d;
    logic [2:0]        funct3_q, funct3_d;

    assign rs1_s = instr_i[19:15];
    assign rs2_s = instr_i[24:20];

    reg_file_p #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we_i),
        .waddr_i  (wb_rd_i),
        .wdata_i  (wb_data_i),
        .raddr1_i (rs1_s),
        .raddr2_i (rs2_s),
        .rdata1_o (rs1_data_s),
        .rdata2_o (rs2_data_s)
    );

    // Both rs fields are compared whatever the format: a conservative stall.
    assign haz_s = in_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
                   ((ex_rd_i == rs1_s) | (ex_rd_i == rs2_s));
    assign in_ready_o = ~rst & ~flush_i & ~haz_s & (~valid_q | out_ready_i);
    assign accept_s   = in_valid_i & in_ready_o;

    // Immediate generation, sign-extended from instr[31].
    always_comb begin
        case (imm_fmt(instr_i[6:0]))
            IMM_I:   imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                                instr_i[11:8], 1'b0};
            IMM_U:   imm32_s = {instr_i[31:12], 12'h000};
            IMM_J:   imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                                instr_i[30:21], 1'b0};
            default: imm32_s = 32'sd0;
        endcase
        imm_s = XLEN'(imm32_s);
    end

    // ID/EX next-state: flush, then accept, then drain, else hold.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7_d   = funct7_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d    = 1'b1;
            pc_d       = pc_i;
            rs1_data_d = rs1_data_s;
            rs2_data_d = rs2_data_s;
            imm_d      = imm_s;
            rs1_d      = rs1_s;
            rs2_d      = rs2_s;
            rd_d       = instr_i[11:7];
            opcode_d   = instr_i[6:0];
            funct3_d   = instr_i[14:12];
            funct7_d   = instr_i[31:25];
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= XLEN'(RESET_PC);
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7_q   <= 7'd0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
        end
    end

    assign out_valid_o    = valid_q;
    assign out_pc_o       = pc_q;
    assign out_rs1_data_o = rs1_data_q;
    assign out_rs2_data_o = rs2_data_q;
    assign out_imm_o      = imm_q;
    assign out_rs1_o      = rs1_q;
    assign out_rs2_o      = rs2_q;
    assign out_rd_o       = rd_q;
    assign out_opcode_o   = opcode_q;
    assign out_funct3_o   = funct3_q;
    assign out_funct7_o   = funct7_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a reference register-file model and an
// output scoreboard; honours ID_WB_BYPASS_EN for the expected read data.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid_i, in_ready_o, wb_we_i, ex_is_load_i, flush_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] instr_i, pc_i, wb_data_i;
    logic [4:0]  wb_rd_i, ex_rd_i;
    logic [31:0] out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o;
    logic [4:0]  out_rs1_o, out_rs2_o, out_rd_o;
    logic [6:0]  out_opcode_o, out_funct7_o;
    logic [2:0]  out_funct3_o;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
        .wb_data_i(wb_data_i), .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_rs1_data_o(out_rs1_data_o), .out_rs2_data_o(out_rs2_data_o),
        .out_imm_o(out_imm_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
        .out_rd_o(out_rd_o), .out_opcode_o(out_opcode_o), .out_funct3_o(out_funct3_o),
        .out_funct7_o(out_funct7_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        logic s;
        s = w[31];
        case (w[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: return {{20{s}}, w[31:20]};
            7'h23:                      return {{20{s}}, w[31:25], w[11:7]};
            7'h63:                      return {{20{s}}, w[7], w[30:25], w[11:8], 1'b0};
            7'h37, 7'h17:               return {w[31:12], 12'h000};
            7'h6f:                      return {{12{s}}, w[19:12], w[20], w[30:21], 1'b0};
            default:                    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we_i && wb_rd_i == idx) return wb_data_i;
`endif
        return mdl[idx];
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.rs1  = w[19:15];
        e.rs2  = w[24:20];
        e.rd   = w[11:7];
        e.op   = w[6:0];
        e.f3   = w[14:12];
        e.f7   = w[31:25];
        e.rs1d = ref_read(w[19:15]);
        e.rs2d = ref_read(w[24:20]);
        e.imm  = ref_imm(w);
        return e;
    endfunction

    // One clock: sample before the edge, update scoreboard and model, then step.
    task automatic cyc();
        exp_t e_now, got, e;
        bit   acc, oh, fl;
        #1;
        acc   = in_valid_i && in_ready_o;
        oh    = out_valid_o && out_ready_i;
        fl    = flush_i && out_valid_o;
        e_now = ref_decode(instr_i, pc_i);
        got   = {out_pc_o, out_rs1_data_o, out_rs2_data_o, out_imm_o, out_rs1_o, out_rs2_o,
                 out_rd_o, out_opcode_o, out_funct3_o, out_funct7_o};
        if (rst) begin
            sb.delete();
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else begin
            if (fl) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (oh) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_out", got, e);
                end
            end
            if (acc) sb.push_back(e_now);
            if (wb_we_i && wb_rd_i != 5'd0) mdl[wb_rd_i] = wb_data_i;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc);
        in_valid_i = 1'b1;
        instr_i    = w;
        pc_i       = pc;
    endtask

    logic [31:0] imm_ins [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h12345237,
                                 32'h0040006F, 32'hFE112E23, 32'h000280B3};
    logic [31:0] imm_exp [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                                 32'h00000004, 32'hFFFFFFFC, 32'h00000000};

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; instr_i = 32'h0; pc_i = 32'h0;
        wb_we_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
        ex_is_load_i = 1'b0; ex_rd_i = 5'd0; flush_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        #1 chk("ready_in_reset", in_ready_o, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_pc", out_pc_o, 32'h0);
        chk("rst_imm", out_imm_o, 32'h0);
        chk("rst_rs1d", out_rs1_data_o, 32'h0);
        chk("rst_rd", out_rd_o, 5'd0);

        // Write x5, then ADD x1,x5,x0
        wb_we_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'h0000_1234;
        cyc();
        wb_we_i = 1'b0;
        drive(32'h000280B3, 32'h100);
        #1 chk("add_ready", in_ready_o, 1'b1);
        cyc();
        in_valid_i = 1'b0;
        chk("add_valid", out_valid_o, 1'b1);
        chk("add_rs1d", out_rs1_data_o, 32'h0000_1234);
        chk("add_rs2d", out_rs2_data_o, 32'h0);
        chk("add_rd", out_rd_o, 5'd1);

        // Write to x0 is discarded
        wb_we_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hDEAD_BEEF;
        cyc();
        wb_we_i = 1'b0;
        drive(32'h000000B3, 32'h104);
        cyc();
        in_valid_i = 1'b0;
        chk("x0_read", out_rs1_data_o, 32'h0);

        // Immediate formats, back to back
        for (int i = 0; i < 6; i++) begin
            drive(imm_ins[i], 32'h108 + 32'(4 * i));
            cyc();
            chk("imm", out_imm_o, imm_exp[i]);
        end
        in_valid_i = 1'b0;

        // Load-use hazard on x5
        ex_is_load_i = 1'b1; ex_rd_i = 5'd5;
        drive(32'h000280B3, 32'h200);
        #1 chk("haz_ready", in_ready_o, 1'b0);
        cyc();
        chk("haz_bubble", out_valid_o, 1'b0);
        ex_is_load_i = 1'b0;
        #1 chk("haz_release", in_ready_o, 1'b1);
        cyc();
        chk("haz_valid", out_valid_o, 1'b1);
        chk("haz_pc", out_pc_o, 32'h200);

        // ex_rd = x0 never stalls
        ex_is_load_i = 1'b1; ex_rd_i = 5'd0;
        drive(32'h000000B3, 32'h204);
        #1 chk("haz_x0_ready", in_ready_o, 1'b1);
        cyc();
        ex_is_load_i = 1'b0; in_valid_i = 1'b0;
        cyc();

        // Backpressure for 3 cycles, then flush
        out_ready_i = 1'b0;
        drive(32'h00100093, 32'h300);
        cyc();
        drive(32'h00200093, 32'h304);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", in_ready_o, 1'b0);
            chk("bp_valid", out_valid_o, 1'b1);
            chk("bp_pc", out_pc_o, 32'h300);
            chk("bp_imm", out_imm_o, 32'h1);
            cyc();
        end
        flush_i = 1'b1;
        #1 chk("flush_ready", in_ready_o, 1'b0);
        cyc();
        flush_i = 1'b0;
        chk("flush_valid", out_valid_o, 1'b0);
        out_ready_i = 1'b1;
        cyc();
        in_valid_i = 1'b0;
        chk("after_flush_pc", out_pc_o, 32'h304);

        // Same-cycle write-back and read of x7
        wb_we_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h11;
        cyc();
        wb_data_i = 32'h55;
        drive(32'h000380B3, 32'h400);
        cyc();
        wb_we_i = 1'b0; in_valid_i = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("wb_same_cycle", out_rs1_data_o, 32'h55);
`else
        chk("wb_same_cycle", out_rs1_data_o, 32'h11);
`endif

        // Reset while the output is stalled
        out_ready_i = 1'b0;
        cyc();
        rst = 1'b1;
        #1 chk("rst_mid_ready", in_ready_o, 1'b0);
        cyc();
        rst = 1'b0; out_ready_i = 1'b1;
        chk("rst_mid_valid", out_valid_o, 1'b0);
        chk("rst_mid_pc", out_pc_o, 32'h0);
        drive(32'h000280B3, 32'h500);
        cyc();
        in_valid_i = 1'b0;
        chk("rst_lost_x5", out_rs1_data_o, 32'h0);

        cyc(); cyc();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
